sum_squares_acc: RTL and testbench

SUM_SQUARES_ACC -- requirements
Module: sum_squares_acc

---
 rtl/sum_squares_acc.sv | 113 +++++++++++
 tb/tb_sum_squares_acc.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sum_squares_acc.sv
// Frame accumulator for squared 3-bit samples: saturating sum, sample count,
// overflow and illegal-square flags, with a one-deep held result and ready/valid handshake.
module sum_squares_acc #(
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned ACC_W     = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_sq,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [7:0]       out_count,
   output logic             out_ovf,
   output logic             out_bad
);

   localparam int unsigned CNT_W = 8;
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   typedef enum logic {ST_ACC, ST_HOLD} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               ovf;
   logic               bad;

   logic               accept_c;
   logic               close_c;
   logic               release_c;
   logic               legal_c;
   logic               sat_c;
   logic [ACC_W:0]     sum_ext_c;
   logic [ACC_W-1:0]   acc_upd_c;
   logic [CNT_W-1:0]   cnt_upd_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_ACC;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACC:  if (close_c)   state_nxt = ST_HOLD;
         ST_HOLD: if (release_c) state_nxt = ST_ACC;
         default: state_nxt = ST_ACC;
      endcase
   end

   // State-decoded outputs; in_ready never depends on in_valid or out_ready
   always_comb begin
      in_ready = 1'b0;
      if (state == ST_ACC) in_ready = 1'b1;
   end

   // Sample update: one extra bit catches the carry that means saturation
   always_comb begin
      legal_c = 1'b0;
      case (in_sq)
         6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49: legal_c = 1'b1;
         default: legal_c = 1'b0;
      endcase
      sum_ext_c = {1'b0, acc} + (ACC_W+1)'(in_sq);
      sat_c     = sum_ext_c[ACC_W];
      acc_upd_c = sat_c ? ACC_MAX : sum_ext_c[ACC_W-1:0];
      cnt_upd_c = cnt + CNT_W'(1);
      accept_c  = in_valid && in_ready;
      close_c   = accept_c && ((cnt_upd_c == CNT_W'(FRAME_LEN)) || in_last);
      release_c = (state == ST_HOLD) && out_ready;
   end

   // Accumulator and held result
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         bad       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         out_bad   <= 1'b0;
      end else if (accept_c) begin
         acc <= acc_upd_c;
         cnt <= cnt_upd_c;
         ovf <= ovf | sat_c;
         bad <= bad | ~legal_c;
         if (close_c) begin
            out_valid <= 1'b1;
            out_sum   <= acc_upd_c;
            out_count <= cnt_upd_c;
            out_ovf   <= ovf | sat_c;
            out_bad   <= bad | ~legal_c;
         end
      end else if (release_c) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         bad       <= 1'b0;
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sum_squares_acc.sv
// Directed bench for sum_squares_acc: a default instance and an ACC_W=6 instance
// share one stimulus stream so saturation is exercised alongside the wide result.
module tb_sum_squares_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [5:0]  in_sq;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_ovf_a, out_bad_a;
   logic [11:0] out_sum_a;
   logic [7:0]  out_count_a;
   logic        in_ready_b, out_valid_b, out_ovf_b, out_bad_b;
   logic [5:0]  out_sum_b;
   logic [7:0]  out_count_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sum_squares_acc dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_sq(in_sq), .in_last(in_last), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
      .out_ovf(out_ovf_a), .out_bad(out_bad_a)
   );

   sum_squares_acc #(.FRAME_LEN(8), .ACC_W(6)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_sq(in_sq), .in_last(in_last), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
      .out_ovf(out_ovf_b), .out_bad(out_bad_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one sample for one edge; inputs stay as-is afterwards
   task automatic send(input logic [5:0] sq, input logic last);
      in_valid = 1'b1;
      in_sq    = sq;
      in_last  = last;
      @(posedge clk);
      #1;
   endtask

   task automatic bubble(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_frame(input string tag, input int sum_a, input int sum_b,
                              input int cnt, input logic ovf_b, input logic bad);
      in_valid = 1'b0;
      in_last  = 1'b0;
      check({tag, ".valid_a"}, 32'(out_valid_a), 32'd1);
      check({tag, ".valid_b"}, 32'(out_valid_b), 32'd1);
      check({tag, ".sum_a"},   32'(out_sum_a),   32'(sum_a));
      check({tag, ".sum_b"},   32'(out_sum_b),   32'(sum_b));
      check({tag, ".count_a"}, 32'(out_count_a), 32'(cnt));
      check({tag, ".count_b"}, 32'(out_count_b), 32'(cnt));
      check({tag, ".ovf_a"},   32'(out_ovf_a),   32'd0);
      check({tag, ".ovf_b"},   32'(out_ovf_b),   32'(ovf_b));
      check({tag, ".bad_a"},   32'(out_bad_a),   32'(bad));
      check({tag, ".ready_a"}, 32'(in_ready_a),  32'd0);
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".drop_a"},  32'(out_valid_a), 32'd0);
      check({tag, ".drop_b"},  32'(out_valid_b), 32'd0);
      check({tag, ".rdy_a"},   32'(in_ready_a),  32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sq = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid", 32'(out_valid_a), 32'd0);
      check("rst.sum",   32'(out_sum_a),   32'd0);
      check("rst.count", 32'(out_count_a), 32'd0);
      check("rst.flags", 32'({out_ovf_a, out_bad_a}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst.ready", 32'(in_ready_a), 32'd1);

      // 8 x 49 back-to-back: 392 wide, saturated narrow
      for (int i = 0; i < 8; i++) send(6'd49, 1'b0);
      check_frame("f49", 392, 63, 8, 1'b1, 1'b0);
      consume("f49");

      // Early close with in_last
      send(6'd1, 1'b0); send(6'd4, 1'b0); send(6'd9, 1'b1);
      check_frame("f149", 14, 14, 3, 1'b0, 1'b0);
      consume("f149");

      // Fresh frame after handshake; narrow instance saturates
      send(6'd49, 1'b0); send(6'd49, 1'b0); send(6'd4, 1'b1);
      check_frame("fsat", 102, 63, 3, 1'b1, 1'b0);
      consume("fsat");

      // Illegal square, then held result under back-pressure with ignored samples
      send(6'd16, 1'b0); send(6'd7, 1'b0); send(6'd0, 1'b1);
      check_frame("fbad", 23, 23, 3, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_sq = 6'd1; in_last = 1'b1;
         @(posedge clk);
         #1;
         check("hold.valid", 32'(out_valid_a), 32'd1);
         check("hold.sum",   32'(out_sum_a),   32'd23);
         check("hold.count", 32'(out_count_a), 32'd3);
         check("hold.bad",   32'(out_bad_a),   32'd1);
         check("hold.ready", 32'(in_ready_a),  32'd0);
      end
      in_valid = 1'b0;
      consume("fbad");

      // Clean frame with bubbles clears the bad flag
      send(6'd0, 1'b0);
      bubble(2);
      check("bubble.valid", 32'(out_valid_a), 32'd0);
      send(6'd1, 1'b1);
      check_frame("fclean", 1, 1, 2, 1'b0, 1'b0);
      consume("fclean");

      // in_last on the very first sample
      send(6'd36, 1'b1);
      check_frame("fone", 36, 36, 1, 1'b0, 1'b0);
      consume("fone");

      // Reset mid-frame, colliding with an accept; partial frame is discarded
      for (int i = 0; i < 5; i++) send(6'd9, 1'b0);
      rst = 1'b1;
      send(6'd9, 1'b1);
      rst = 1'b0;
      in_valid = 1'b0; in_last = 1'b0;
      check("rstmid.valid", 32'(out_valid_a), 32'd0);
      check("rstmid.ready", 32'(in_ready_a),  32'd1);
      for (int i = 0; i < 3; i++) send(6'd1, 1'b0);
      in_valid = 1'b0;
      check("rstmid.nores", 32'(out_valid_a), 32'd0);
      for (int i = 0; i < 5; i++) send(6'd1, 1'b0);
      check_frame("fpost", 8, 8, 8, 1'b0, 1'b0);
      consume("fpost");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
